param_call_stack: RTL

Parametrised successor to the CPU call/interrupt stack. Saves a return address (in_pc + RET_OFFSET) together with the flag word on push, and restores them on pop. Adds:
- configurable width and depth
- selectable overflow policy
- simultaneous push+pop (replace top)
- synchronous reset
- occupancy and status outputs

Sits beside the PC/flags registers in the control path and is driven by the CALL/RET/interrupt sequencer.

---
 rtl/param_call_stack_pkg.sv | 8 +
 rtl/param_call_stack_stack_ptr_ctrl.sv | 60 ++++++
 rtl/param_call_stack.sv | 60 ++++++
 3 files changed

// File: rtl/param_call_stack_pkg.sv
// param_call_stack_pkg: shared constants and sizing helper for the parametrised call stack
package param_call_stack_pkg;
  localparam int OVF_OVERWRITE_TOP = 0;
  localparam int OVF_DROP_OLDEST = 1;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/param_call_stack_stack_ptr_ctrl.sv
// stack_ptr_ctrl: occupancy, circular base pointer, slot selection and status pulses for the call stack
module stack_ptr_ctrl
  import param_call_stack_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int OVF_MODE = OVF_OVERWRITE_TOP,
  localparam int CW = cnt_w(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o,
  output logic          underflow_o,
  output logic          wr_en_o,
  output logic [PW-1:0] wr_idx_o,
  output logic [PW-1:0] rd_idx_o
);
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] base_q, base_d, top_idx;
  logic ovf_q, unf_q, replace, grow, ovf, drop;
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = (CW+1)'(a) + (CW+1)'(b);
    return PW'(s >= (CW+1)'(DEPTH) ? s - (CW+1)'(DEPTH) : s);
  endfunction
  assign empty_o = count_q == '0;
  assign full_o = count_q == CW'(DEPTH);
  assign top_idx = empty_o ? base_q : wrap(base_q, count_q - 1'b1);
  assign replace = push_i & pop_i & !empty_o;
  assign grow = push_i & !replace & !full_o;
  assign ovf = push_i & !pop_i & full_o;
  // dropping the oldest rotates the base: the freed bottom slot becomes the new top
  assign drop = ovf & (OVF_MODE == OVF_DROP_OLDEST);
  assign wr_en_o = push_i;
  assign wr_idx_o = grow ? wrap(base_q, count_q) : drop ? base_q : top_idx;
  assign rd_idx_o = top_idx;
  assign count_d = grow ? count_q + 1'b1 : (pop_i & !push_i & !empty_o) ? count_q - 1'b1 : count_q;
  assign base_d = drop ? wrap(base_q, CW'(1)) : base_q;
  assign count_o = count_q;
  assign overflow_o = ovf_q;
  assign underflow_o = unf_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      base_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      count_q <= count_d;
      base_q <= base_d;
      ovf_q <= ovf;
      unf_q <= pop_i & !push_i & empty_o;
    end
  end
endmodule

// File: rtl/param_call_stack.sv
// param_call_stack: return-address/flags stack with configurable depth and overflow policy
module param_call_stack
  import param_call_stack_pkg::*;
#(
  parameter int PC_WIDTH = 9,
  parameter int FLAGS_WIDTH = 4,
  parameter int DEPTH = 5,
  parameter int RET_OFFSET = 1,
  parameter int OVF_MODE = OVF_OVERWRITE_TOP,
  localparam int CW = cnt_w(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_en,
  input  logic                   pop_en,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [FLAGS_WIDTH-1:0] in_flags,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [FLAGS_WIDTH-1:0] out_flags,
  output logic [CW-1:0]          count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);
  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [FLAGS_WIDTH-1:0] flags;
  } entry_t;
  entry_t mem_q [DEPTH];
  entry_t wr_d, top;
  logic wr_en;
  logic [PW-1:0] wr_idx, rd_idx;
  stack_ptr_ctrl #(.DEPTH(DEPTH), .OVF_MODE(OVF_MODE)) u_ptr (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(push_en),
    .pop_i(pop_en),
    .count_o(count),
    .empty_o(empty),
    .full_o(full),
    .overflow_o(overflow),
    .underflow_o(underflow),
    .wr_en_o(wr_en),
    .wr_idx_o(wr_idx),
    .rd_idx_o(rd_idx)
  );
  assign wr_d = '{pc: in_pc + PC_WIDTH'(RET_OFFSET), flags: in_flags};
  assign top = mem_q[rd_idx];
  assign out_pc = empty ? '0 : top.pc;
  assign out_flags = empty ? '0 : top.flags;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_d;
    end
  end
endmodule
